// File: rtl/cellram_ctrl.sv
// Burst sequencer for an 8M x 16 Cellular RAM: turns host read/write burst commands
// and BCR writes into ce/adv/we/oe/cre pin sequences paced by mem_wait.
`timescale 1ns/1ps
module cellram_ctrl #(
  parameter logic [22:0] BCR_INIT     = 23'h009D1F,
  parameter int          RD_LATENCY   = 1,
  parameter int          WAIT_TIMEOUT = 16,
  parameter int          CFG_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [22:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [8:0]  wr_level,
  input  logic [15:0] wr_data,
  output logic        wr_pop,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        cfg_valid,
  input  logic [22:0] cfg_data,
  output logic        cfg_ready,
  output logic        init_done,
  output logic        err_timeout,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_oe,
  output logic        mem_adv,
  output logic        mem_cre,
  output logic        mem_lb,
  output logic        mem_ub,
  output logic [22:0] mem_addr,
  inout  wire  [15:0] mem_data,
  input  logic        mem_wait
);

  localparam int WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);
  localparam logic [8:0]    CFG_LAST  = 9'(CFG_CYCLES - 2);
  localparam logic [9:0]    RL_FIRST  = 10'(RD_LATENCY - 1);
  localparam logic [9:0]    RL_CYC    = 10'(RD_LATENCY);

  typedef enum logic [2:0] {
    CFG_ADDR, CFG_HOLD, GAP, IDLE, ADDR, WAIT, WBURST, RBURST
  } state_t;

  state_t      state_reg;
  logic [22:0] cfg_value_reg;
  logic [22:0] addr_reg;
  logic [7:0]  len_reg;
  logic        dir_reg;
  logic [8:0]  cnt_reg;
  logic [WW-1:0] wait_cnt_reg;
  logic        wait_pol_reg;
  logic        init_done_reg;
  logic        err_reg;
  logic        rd_valid_reg;
  logic [15:0] rd_data_reg;

  logic [8:0]  cmd_words;
  logic [9:0]  cnt_wide;
  logic [9:0]  len_wide;
  logic        rd_sample;
  logic        rd_last;

  assign cmd_words = {1'b0, cmd_len} + 9'd1;
  assign cnt_wide  = {1'b0, cnt_reg};
  assign len_wide  = {2'b00, len_reg};
  // Word i is on the bus in RBURST cycle RD_LATENCY-1+i; it is strobed out one cycle later.
  assign rd_sample = (cnt_wide >= RL_FIRST) && (cnt_wide <= len_wide + RL_FIRST);
  assign rd_last   = (cnt_wide == len_wide + RL_CYC);

  assign cfg_ready = !reset && (state_reg == IDLE) && init_done_reg;
  assign cmd_ready = !reset && (state_reg == IDLE) && init_done_reg && !cfg_valid &&
                     (!cmd_write || (wr_level >= cmd_words));

  assign wr_pop      = !reset && (state_reg == WBURST);
  assign mem_data    = wr_pop ? wr_data : 16'bz;
  assign rd_data     = rd_data_reg;
  assign rd_valid    = rd_valid_reg;
  assign init_done   = init_done_reg;
  assign err_timeout = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= CFG_ADDR;
      cfg_value_reg <= BCR_INIT;
      addr_reg      <= '0;
      len_reg       <= '0;
      dir_reg       <= 1'b0;
      cnt_reg       <= '0;
      wait_cnt_reg  <= '0;
      wait_pol_reg  <= 1'b1;
      init_done_reg <= 1'b0;
      err_reg       <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      err_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      case (state_reg)
        CFG_ADDR: begin
          cnt_reg   <= '0;
          state_reg <= CFG_HOLD;
        end
        CFG_HOLD: begin
          if (cnt_reg == CFG_LAST) begin
            wait_pol_reg <= cfg_value_reg[10];
            state_reg    <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        GAP: begin
          init_done_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            cfg_value_reg <= cfg_data;
            state_reg     <= CFG_ADDR;
          end else if (cmd_valid && cmd_ready) begin
            addr_reg  <= cmd_addr;
            len_reg   <= cmd_len;
            dir_reg   <= cmd_write;
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (mem_wait != wait_pol_reg) begin
            cnt_reg   <= '0;
            state_reg <= dir_reg ? WBURST : RBURST;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= GAP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        WBURST: begin
          if (cnt_reg == {1'b0, len_reg}) begin
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        RBURST: begin
          if (rd_sample) begin
            rd_data_reg  <= mem_data;
            rd_valid_reg <= 1'b1;
          end
          if (rd_last) begin
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        default: state_reg <= GAP;
      endcase
    end
  end

  // Pins are a pure decode of registered state; reset forces every control inactive.
  always_comb begin
    mem_ce   = 1'b1;
    mem_we   = 1'b1;
    mem_oe   = 1'b1;
    mem_adv  = 1'b1;
    mem_cre  = 1'b0;
    mem_lb   = 1'b1;
    mem_ub   = 1'b1;
    mem_addr = '0;
    if (!reset) begin
      case (state_reg)
        CFG_ADDR: begin
          // Register write: the address cycle carries the BCR value with adv/we low.
          mem_ce   = 1'b0;
          mem_cre  = 1'b1;
          mem_adv  = 1'b0;
          mem_we   = 1'b0;
          mem_addr = cfg_value_reg;
        end
        CFG_HOLD: begin
          mem_ce   = 1'b0;
          mem_addr = cfg_value_reg;
        end
        ADDR: begin
          mem_ce   = 1'b0;
          mem_adv  = 1'b0;
          mem_we   = ~dir_reg;
          mem_lb   = 1'b0;
          mem_ub   = 1'b0;
          mem_addr = addr_reg;
        end
        WAIT: begin
          mem_ce   = 1'b0;
          mem_oe   = dir_reg;
          mem_lb   = 1'b0;
          mem_ub   = 1'b0;
          mem_addr = addr_reg;
        end
        WBURST: begin
          mem_ce   = 1'b0;
          mem_lb   = 1'b0;
          mem_ub   = 1'b0;
          mem_addr = addr_reg;
        end
        RBURST: begin
          mem_ce   = 1'b0;
          mem_oe   = 1'b0;
          mem_lb   = 1'b0;
          mem_ub   = 1'b0;
          mem_addr = addr_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cellram_ctrl.sv
// Directed bench for cellram_ctrl with a small cellram model that holds mem_wait for
// wait_hold WAIT cycles, stores write bursts and returns them on read bursts.
`timescale 1ns/1ps
module tb_cellram_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [22:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [8:0]  wr_level;
  logic [15:0] wr_data;
  logic        wr_pop;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        cfg_valid, cfg_ready;
  logic [22:0] cfg_data;
  logic        init_done, err_timeout;
  logic        mem_ce, mem_we, mem_oe, mem_adv, mem_cre, mem_lb, mem_ub;
  logic [22:0] mem_addr;
  wire  [15:0] mem_data;
  logic        mem_wait;

  cellram_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_level(wr_level), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .init_done(init_done), .err_timeout(err_timeout),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_oe(mem_oe), .mem_adv(mem_adv),
    .mem_cre(mem_cre), .mem_lb(mem_lb), .mem_ub(mem_ub),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wait(mem_wait)
  );

  always #5 clk = ~clk;

  // Show-ahead write FIFO: word k is 16'hA000 + k.
  int loaded = 0;
  int popped = 0;
  assign wr_level = 9'(loaded - popped);
  assign wr_data  = 16'hA000 + 16'(popped);
  always @(posedge clk) if (wr_pop) popped <= popped + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cellram model
  int          wait_hold = 2;
  logic        dev_active = 1'b0;
  int          dev_cnt = 0;
  logic        dev_wr = 1'b0;
  logic [7:0]  dev_base = '0;
  logic [15:0] dev_mem [256];
  logic        dev_drive = 1'b0;
  logic [15:0] dev_q = '0;
  logic        dev_wait = 1'b1;
  assign mem_wait = dev_wait;
  assign mem_data = dev_drive ? dev_q : 16'bz;
  initial for (int i = 0; i < 256; i++) dev_mem[i] = 16'h0000;

  always @(negedge clk) begin
    if (!mem_ce && !mem_adv && !mem_cre) begin
      dev_active <= 1'b1;
      dev_cnt    <= 0;
      dev_wr     <= !mem_we;
      dev_base   <= mem_addr[7:0];
      dev_wait   <= 1'b1;
      dev_drive  <= 1'b0;
    end else if (mem_ce) begin
      dev_active <= 1'b0;
      dev_wait   <= 1'b1;
      dev_drive  <= 1'b0;
    end else if (dev_active) begin
      dev_cnt <= dev_cnt + 1;
      if (dev_cnt + 1 > wait_hold) dev_wait <= 1'b0;
      if (dev_cnt + 1 >= wait_hold + 2) begin
        if (dev_wr) dev_mem[8'(dev_base + 8'(dev_cnt + 1 - wait_hold - 2))] <= mem_data;
        else if (!mem_oe) begin
          dev_drive <= 1'b1;
          dev_q     <= dev_mem[8'(dev_base + 8'(dev_cnt + 1 - wait_hold - 2))];
        end
      end
    end
  end

  // Event log
  int          pop_q[$];
  int          rdv_q[$];
  int          err_q[$];
  int          addr_q[$];
  logic [15:0] rdd_q[$];
  int          ce_log [4096];
  always @(negedge clk) begin
    ce_log[cyc % 4096] = int'(mem_ce);
    if (wr_pop) pop_q.push_back(cyc);
    if (rd_valid) begin
      rdv_q.push_back(cyc);
      rdd_q.push_back(rd_data);
    end
    if (err_timeout) err_q.push_back(cyc);
    if (!mem_ce && !mem_adv && !mem_cre) addr_q.push_back(cyc);
  end

  function automatic int ce_at(input int c);
    return (c < 0) ? 2 : ce_log[c % 4096];
  endfunction

  task automatic clear_log();
    pop_q.delete(); rdv_q.delete(); err_q.delete(); addr_q.delete(); rdd_q.delete();
  endtask

  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [22:0] a, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
  endtask

  int a;

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cfg_valid = 1'b0; cfg_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ce", mem_ce, 1);
    check("rst_cre", mem_cre, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_ctl", {mem_we, mem_oe, mem_adv, mem_lb, mem_ub}, 5'b11111);
    check("rst_flags", {cmd_ready, cfg_ready, wr_pop, rd_valid, init_done, err_timeout}, 6'b0);

    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    $display("init: BCR write after reset");
    check("cfg0_ce_cre", {mem_ce, mem_cre}, 2'b01);
    check("cfg0_addr", mem_addr, 23'h009D1F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cfg0_hold", {mem_ce, mem_cre}, 2'b00);
    end
    @(negedge clk);
    check("cfg0_gap_ce", mem_ce, 1);
    check("cfg0_gap_init", init_done, 0);
    @(negedge clk);
    check("idle_init", init_done, 1);
    check("idle_cfg_ready", cfg_ready, 1);

    // Write burst
    clear_log();
    loaded = popped + 4;
    issue(1'b1, 23'h000100, 8'd3);
    #1 check("wr_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    $display("write burst addr=000100 len=3");
    repeat (14) @(negedge clk);
    a = (addr_q.size() > 0) ? addr_q[0] : -100;
    check("wr_addr_cycles", addr_q.size(), 1);
    check("wr_pop_count", pop_q.size(), 4);
    check("wr_first_pop", (pop_q.size() > 0) ? pop_q[0] - a : -1, 4);
    check("wr_last_pop", (pop_q.size() > 3) ? pop_q[3] - a : -1, 7);
    check("wr_ce_last_pop", ce_at(a + 7), 0);
    check("wr_ce_after", ce_at(a + 8), 1);

    // Read back
    clear_log();
    issue(1'b0, 23'h000100, 8'd3);
    #1 check("rd_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    $display("read burst addr=000100 len=3");
    repeat (14) @(negedge clk);
    a = (addr_q.size() > 0) ? addr_q[0] : -100;
    check("rd_valid_count", rdv_q.size(), 4);
    check("rd_first_valid", (rdv_q.size() > 0) ? rdv_q[0] - a : -1, 5);
    check("rd_last_valid", (rdv_q.size() > 3) ? rdv_q[3] - a : -1, 8);
    for (int i = 0; i < 4; i++)
      check("rd_word", (rdd_q.size() > i) ? 32'(rdd_q[i]) : 32'hFFFF_FFFF, 32'hA000 + 32'(i));
    check("rd_no_pop", pop_q.size(), 0);

    // Config and command together
    clear_log();
    cfg_valid = 1'b1; cfg_data = 23'h001D00;
    issue(1'b0, 23'h000100, 8'd0);
    #1 check("cc_cmd_ready", cmd_ready, 0);
    check("cc_cfg_ready", cfg_ready, 1);
    @(posedge clk); #1 cfg_valid = 1'b0;
    $display("config write 001D00 with pending read");
    @(negedge clk);
    check("cc_cfg_addr", mem_addr, 23'h001D00);
    check("cc_cfg_cre", {mem_ce, mem_cre, cmd_ready}, 3'b010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cc_busy_ready", cmd_ready, 0);
    end
    @(negedge clk);
    #1 check("cc_idle_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    $display("read burst addr=000100 len=0");
    repeat (12) @(negedge clk);
    check("cc_rd_count", rdv_q.size(), 1);
    check("cc_rd_word", (rdd_q.size() > 0) ? 32'(rdd_q[0]) : 32'hFFFF_FFFF, 32'hA000);

    // Write held back by FIFO level
    clear_log();
    loaded = popped + 2;
    issue(1'b1, 23'h000110, 8'd3);
    #1 check("lv_ready_low", cmd_ready, 0);
    repeat (3) @(negedge clk);
    check("lv_still_idle", {mem_ce, cmd_ready}, 2'b10);
    check("lv_no_addr", addr_q.size(), 0);
    loaded = popped + 4;
    #1 check("lv_ready_high", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    $display("write burst addr=000110 len=3 after level reached 4");
    repeat (14) @(negedge clk);
    check("lv_pop_count", pop_q.size(), 4);

    // WAIT timeout
    clear_log();
    wait_hold = 1000;
    issue(1'b0, 23'h000120, 8'd1);
    #1 check("to_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    $display("read burst addr=000120 len=1 with wait stuck");
    repeat (22) @(negedge clk);
    a = (addr_q.size() > 0) ? addr_q[0] : -100;
    check("to_err_count", err_q.size(), 1);
    check("to_err_cycle", (err_q.size() > 0) ? err_q[0] - a : -1, 17);
    check("to_ce_wait", ce_at(a + 16), 0);
    check("to_ce_gap", ce_at(a + 17), 1);
    check("to_no_data", rdv_q.size() + pop_q.size(), 0);
    wait_hold = 2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
